// File: rtl/fetch_prefetch_buffer_pkg.sv
// rtl/fetch_prefetch_buffer_pkg.sv - shared fetch front-end definitions
package fetch_prefetch_buffer_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    // One buffered fetch result: bus error flag, its PC, and the returned word.
    typedef struct packed {
        logic               fault;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Word-align an address by clearing the two byte-offset bits.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_prefetch_buffer_fifo.sv
// rtl/fetch_prefetch_buffer_fifo.sv - parameterised synchronous FIFO with flush
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       i_reset,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_do_push   = i_push && !o_full && !i_flush;
    assign w_do_pop    = i_pop && !o_empty && !i_flush;
    assign o_count     = r_count;
    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_head_data = r_mem[r_rd_ptr];

    // Storage array: written on push only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// rtl/fetch_prefetch_buffer.sv - sequential instruction prefetch with redirect flush
module fetch_prefetch_buffer
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        instr_ready_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        fault_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [PC_W-1:0]  r_fetch_addr;
    logic [PC_W-1:0]  r_resp_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_discard;

    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_entry;
    logic [SUM_W-1:0] w_in_use;
    logic             w_req;
    logic             w_gnt;
    logic             w_rsp;
    logic             w_push;
    logic             w_pop;
    logic [PC_W-1:0]  w_redirect_pc;

    // Occupancy cap counts both buffered words and words still on the bus.
    assign w_in_use      = SUM_W'(w_fifo_count) + SUM_W'(r_outstanding);
    assign w_req         = !reset && !redirect_i && (w_in_use < SUM_W'(DEPTH));
    assign w_gnt         = w_req && imem_gnt_i;
    assign w_rsp         = imem_rvalid_i && (r_outstanding != '0);
    assign w_push        = w_rsp && (r_discard == '0) && !redirect_i && !reset && !w_fifo_full;
    assign w_pop         = instr_valid_o && instr_ready_i;
    assign w_redirect_pc = word_align(redirect_pc_i);

    assign w_push_entry = '{fault: imem_err_i, pc: r_resp_pc, instr: imem_rdata_i};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .i_reset     (reset),
        .i_flush     (redirect_i),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // In-flight and to-be-dropped response counters; a response retiring in
    // the redirect cycle is removed from the discard count immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= r_outstanding + CNT_W'(w_gnt) - CNT_W'(w_rsp);
            if (redirect_i) begin
                r_discard <= r_outstanding - CNT_W'(w_rsp) + CNT_W'(w_gnt);
            end else if (w_rsp && (r_discard != '0)) begin
                r_discard <= r_discard - CNT_W'(1);
            end
        end
    end

    // Request address and response PC both restart at the redirect target.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_addr <= RESET_PC;
            r_resp_pc    <= RESET_PC;
        end else if (redirect_i) begin
            r_fetch_addr <= w_redirect_pc;
            r_resp_pc    <= w_redirect_pc;
        end else begin
            if (w_gnt) begin
                r_fetch_addr <= r_fetch_addr + 32'd4;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + 32'd4;
            end
        end
    end

    assign instr_valid_o = !w_fifo_empty;
    assign instr_o       = w_head.instr;
    assign pc_o          = w_head.pc;
    assign fault_o       = instr_valid_o && w_head.fault;
    assign imem_req_o    = w_req;
    assign imem_addr_o   = r_fetch_addr;

endmodule
